// File: rtl/axis_video_crop_pp.sv
// AXI4-Stream video cropper: forwards only beats inside a per-frame window,
// measures the incoming frame size and flags misplaced start-of-frame markers.
module axis_video_crop_pp #(
  parameter int PPC   = 2,
  parameter int BPC   = 8,
  parameter int NCH   = 3,
  parameter int DIM_W = 13
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic                   enable,
  input  logic [DIM_W-1:0]       crop_x,
  input  logic [DIM_W-1:0]       crop_y,
  input  logic [DIM_W-1:0]       crop_w,
  input  logic [DIM_W-1:0]       crop_h,
  input  logic [PPC*NCH*BPC-1:0] s_tdata,
  input  logic                   s_tvalid,
  input  logic                   s_tuser,
  input  logic                   s_tlast,
  output logic                   s_tready,
  output logic [PPC*NCH*BPC-1:0] m_tdata,
  output logic                   m_tvalid,
  output logic                   m_tuser,
  output logic                   m_tlast,
  input  logic                   m_tready,
  output logic [DIM_W-1:0]       meas_w,
  output logic [DIM_W-1:0]       meas_h,
  output logic                   frame_done,
  output logic                   err_sof
);

  typedef enum logic [1:0] {IDLE, WAIT_SOF, IN_FRAME} state_t;

  localparam logic [DIM_W-1:0] ALIGN = ~DIM_W'(PPC - 1);

  state_t           state, state_nxt;
  logic [DIM_W-1:0] x, y, wx, wy, ww, wh;
  logic             first_pend;

  logic             acc, sof, out_free, sof_start, sof_good, sof_bad, live;
  logic             hit, fwd_last, first_now;
  logic [DIM_W-1:0] bx, by, cx, cy, cw, ch;
  logic [DIM_W:0]   x_end, y_end, bx_next;

  function automatic logic [DIM_W-1:0] sat(input logic [DIM_W:0] v);
    return v[DIM_W] ? '1 : v[DIM_W-1:0];
  endfunction

  assign out_free = !m_tvalid || m_tready;
  assign s_tready = (state == IDLE) ? 1'b1 : out_free;
  assign acc      = s_tvalid && s_tready;
  assign sof      = acc && s_tuser;

  // A SOF beat both opens the frame and is pixel (0,0) of it, using the live window.
  assign sof_start = sof && enable && (state != IDLE);
  assign sof_good  = sof && (state == IN_FRAME) && (x == '0) && (y != '0);
  assign sof_bad   = sof && (state == IN_FRAME) && !((x == '0) && (y != '0));
  assign live      = sof_start || (acc && !s_tuser && (state == IN_FRAME));

  assign bx = sof_start ? '0 : x;
  assign by = sof_start ? '0 : y;
  assign cx = sof_start ? (crop_x & ALIGN) : wx;
  assign cy = sof_start ? crop_y : wy;
  assign cw = sof_start ? (crop_w & ALIGN) : ww;
  assign ch = sof_start ? crop_h : wh;

  assign x_end     = {1'b0, cx} + {1'b0, cw};
  assign y_end     = {1'b0, cy} + {1'b0, ch};
  assign bx_next   = {1'b0, bx} + (DIM_W+1)'(PPC);
  assign hit       = live && (by >= cy) && ({1'b0, by} < y_end)
                          && (bx >= cx) && ({1'b0, bx} < x_end);
  assign fwd_last  = (bx_next == x_end) || s_tlast;
  assign first_now = sof_start || first_pend;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (enable) state_nxt = WAIT_SOF;
      WAIT_SOF: if (sof) state_nxt = enable ? IN_FRAME : IDLE;
      IN_FRAME: if (sof && !enable) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // NOTE: all clocked state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      x          <= '0;
      y          <= '0;
      wx         <= '0;
      wy         <= '0;
      ww         <= '0;
      wh         <= '0;
      first_pend <= 1'b0;
      meas_w     <= '0;
      meas_h     <= '0;
      frame_done <= 1'b0;
      err_sof    <= 1'b0;
      m_tvalid   <= 1'b0;
      m_tuser    <= 1'b0;
      m_tlast    <= 1'b0;
      m_tdata    <= '0;
    end else begin
      frame_done <= 1'b0;
      if (sof_good) begin
        meas_h     <= y;
        frame_done <= 1'b1;
      end
      if (sof_bad) err_sof <= 1'b1;

      if (sof_start) begin
        wx         <= cx;
        wy         <= cy;
        ww         <= cw;
        wh         <= ch;
        first_pend <= 1'b1;
      end
      if (hit) first_pend <= 1'b0;

      if (live) begin
        x <= s_tlast ? '0 : sat(bx_next);
        y <= s_tlast ? sat({1'b0, by} + (DIM_W+1)'(1)) : by;
        if (s_tlast && (by == '0)) meas_w <= sat(bx_next);
      end

      // Output slot only reloads when empty or draining, which holds data under stall.
      if (out_free) begin
        m_tvalid <= hit;
        if (hit) begin
          m_tdata <= s_tdata;
          m_tuser <= first_now;
          m_tlast <= fwd_last;
        end
      end
    end
  end

endmodule

// File: doc/axis_video_crop_pp.md
AXIS_VIDEO_CROP_PP -- requirements
Module: axis_video_crop_pp

Interface
REQ-001 SHALL have parameter PPC, default 2, meaning pixels per beat (1, 2 or 4).
REQ-002 SHALL have parameter BPC, default 8, meaning bits per colour component (8, 10, 12 or 16).
REQ-003 SHALL have parameter NCH, default 3, meaning components per pixel (1 to 3).
REQ-004 SHALL have parameter DIM_W, default 13, meaning width of all size and coordinate ports; TW below denotes PPC*NCH*BPC.
REQ-005 SHALL have port aclk, input, 1, the single clock.
REQ-006 SHALL have port areset, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port enable, input, 1; when high, the block locks to the next frame start.
REQ-008 SHALL have ports crop_x, crop_y, crop_w, crop_h, inputs, DIM_W each, giving the crop window in pixels; crop_x and crop_w low log2(PPC) bits are ignored.
REQ-009 SHALL have ports s_tdata (TW), s_tvalid, s_tuser, s_tlast as inputs and s_tready as output, forming the AXI4-Stream video slave.
REQ-010 SHALL have ports m_tdata (TW), m_tvalid, m_tuser, m_tlast as outputs and m_tready as input, forming the AXI4-Stream video master.
REQ-011 SHALL have ports meas_w and meas_h, outputs, DIM_W each, giving the measured input frame size in pixels and lines.
REQ-012 SHALL have port frame_done, output, 1, a one-cycle pulse when a frame is measured.
REQ-013 SHALL have port err_sof, output, 1, a sticky flag for early or missing SOF, cleared by reset only.

Function
REQ-014 SHALL implement a state machine with states IDLE, WAIT_SOF and IN_FRAME.
REQ-015 IDLE SHALL go to WAIT_SOF when enable=1, and any state SHALL return to IDLE at the next SOF boundary once enable=0.
REQ-016 WAIT_SOF SHALL consume input beats (s_tready=1) and discard them until an accepted beat with s_tuser=1, then go to IN_FRAME.
REQ-017 SHALL latch crop_x/y/w/h only on an accepted SOF beat, so that the window is constant for the whole frame.
REQ-018 SHALL track the beat column (x, in pixels, +PPC per beat, reset on accepted s_tlast) and the line (y, +1 on accepted s_tlast).
REQ-019 SHALL forward a beat only if crop_x <= x < crop_x+crop_w and crop_y <= y < crop_y+crop_h; all other accepted beats SHALL be dropped.
REQ-020 SHALL set m_tuser=1 on the first forwarded beat of each frame only.
REQ-021 SHALL set m_tlast=1 on a forwarded beat when x+PPC = crop_x+crop_w or when s_tlast=1, which clamps the window to the input line.
REQ-022 SHALL register the output with latency 1 cycle from acceptance to m_tvalid, and SHALL drive s_tready = !m_tvalid || m_tready.
REQ-023 SHALL keep m_tdata/m_tuser/m_tlast stable while m_tvalid=1 and m_tready=0.
REQ-024 SHALL form an accepted beat as s_tvalid && s_tready; in IDLE, s_tready SHALL be 1 and beats SHALL be discarded.
REQ-025 SHALL measure meas_w as x+PPC at the first s_tlast of the frame.
REQ-026 On the next accepted SOF, SHALL update meas_h to y and pulse frame_done for 1 cycle.
REQ-027 An accepted s_tuser=1 with x!=0 or y=0 in IN_FRAME (SOF mid-frame) SHALL set err_sof, restart the frame (x=y=0), relatch the window, and suppress frame_done.
REQ-028 An accepted s_tuser=1 and s_tlast=1 on the same beat SHALL be treated as SOF, then as end of line 0.
REQ-029 crop_w=0 or crop_h=0 SHALL forward nothing and SHALL NOT stall the input.
REQ-030 Counters SHALL saturate at 2^DIM_W-1 and SHALL NOT wrap.

Reset
REQ-031 While areset=1, SHALL hold state=IDLE, m_tvalid=0, m_tuser=0, m_tlast=0, m_tdata=0, meas_w=0, meas_h=0, frame_done=0, err_sof=0, and x=y=0.
REQ-032 Asserting areset mid-frame SHALL abort immediately; after release the block SHALL re-enter WAIT_SOF only via enable and resume at the next SOF.

Verification
REQ-033 PPC=2, 480x640 input, window (0,0,480,640), m_tready=1 -> output identical to input; frame_done at the second SOF with meas_w=480 and meas_h=640.
REQ-034 Window (100,50,64,32) on 480x640 -> 32 lines of 32 beats each; m_tuser on the first beat only; m_tlast every 32nd beat; data equals input pixels 100..163.
REQ-035 Window (448,0,64,4) -> each line is clamped to 16 beats, with m_tlast coinciding with input s_tlast.
REQ-036 m_tready random 50% during REQ-034 -> no beat lost or duplicated, and output stable under stall.
REQ-037 SOF injected at line 10 mid-line -> err_sof=1, no frame_done for the truncated frame, and the next frame is cropped correctly.
REQ-038 areset pulsed mid-frame with enable=1 -> all outputs zero; the first output after release carries m_tuser=1 at the following SOF.
